// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back path.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  function automatic logic is_zero_reg(input logic [REG_AW-1:0] r);
    return r == '0;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bit per architectural register; raises issue_stall on RAW/WAW hazards.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            rf_we,
  input  logic [AW-1:0]   rf_addr,
  output logic            issue_stall,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q, busy_d, set_vec, clr_vec;

  // Register 0 is never marked busy, so it can never cause a stall.
  assign issue_stall = issue_valid &&
                       (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
  assign busy = busy_q;

  // Set beats clear when both hit the same register at one edge.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && !issue_stall && !is_zero_reg(REG_AW'(issue_rd)))
      set_vec[issue_rd] = 1'b1;
    if (rf_we)
      clr_vec[rf_addr] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Merges load and ALU write-back into the single register-file write port.
module regfile_wb_scheduler
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_stall,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              load_valid,
  input  logic [REG_AW-1:0] load_rd,
  input  logic [XLEN-1:0]   load_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREG-1:0]   busy,
  output logic              load_conflict
);

  localparam int unsigned DW = wb_pkg::XLEN;

  wb_req_t hold_q, hold_d, wr, alu_req;
  logic    alu_fire, sel_load;

  assign alu_ready = !hold_q.valid;
  assign alu_fire  = alu_valid && alu_ready;
  assign alu_req   = '{valid: 1'b1, rd: alu_rd, data: DW'(alu_data)};

  // Fixed priority: load, then held ALU result, then direct ALU result.
  always_comb begin
    wr       = '0;
    hold_d   = hold_q;
    sel_load = 1'b0;
    if (load_valid) begin
      wr       = '{valid: 1'b1, rd: load_rd, data: DW'(load_data)};
      sel_load = 1'b1;
      if (alu_fire) hold_d = alu_req;
    end else if (hold_q.valid) begin
      wr           = hold_q;
      hold_d.valid = 1'b0;
    end else if (alu_fire) begin
      wr = alu_req;
    end
  end

  // Writes to x0 consume their slot but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q        <= '0;
      rf_we         <= 1'b0;
      rf_addr       <= '0;
      rf_wdata      <= '0;
      load_conflict <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rf_we  <= wr.valid && !is_zero_reg(wr.rd);
      if (wr.valid) begin
        rf_addr  <= wr.rd;
        rf_wdata <= XLEN'(wr.data);
      end
      if (load_valid && !sel_load) load_conflict <= 1'b1;
    end
  end

  wb_scoreboard #(.NREG(NREG), .AW(REG_AW)) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .issue_stall (issue_stall),
    .busy        (busy)
  );

endmodule
